// File: rtl/mlaccel_vecfetch.sv
// Read-stream sequencer: turns (addr, len) commands into back-to-back 64-bit memory
// reads, tracks the fixed read latency and returns the data through a credit-checked FIFO.
module mlaccel_vecfetch #(
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP  = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_len,
  output logic [15:0] mem_addr,
  output logic [1:0]  mem_wen,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [15:0] addr_q;
  logic [15:0] rem;
  logic [15:0] addr_hold;
  logic        done_q;
  logic        done_nxt;
  logic        issue;
  logic        cmd_fire;
  logic        last_fire;

  logic [READ_LAT-1:0] pipe_vld;
  logic [READ_LAT-1:0] pipe_last;
  logic [INF_W-1:0]    inflight;

  logic [64:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [CNT_W:0]   credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign cmd_ready = (state == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign mem_wen   = 2'b00;
  assign mem_addr  = issue ? addr_q : addr_hold;

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_mem[rd_ptr][63:0];
  assign out_last  = out_valid && fifo_mem[rd_ptr][64];
  assign fifo_rd   = out_valid && out_ready;
  assign fifo_wr   = pipe_vld[READ_LAT-1];
  assign last_fire = fifo_rd && out_last;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + INF_W'(pipe_vld[i]);
    end
  end

  // Reads still in the pipe already own a FIFO slot, so the FIFO can never overflow.
  assign credit_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == 16'd0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if ((rem != 16'd0) && (credit_used < (CNT_W+1)'(FIFO_DEPTH))) begin
          issue = 1'b1;
          if (rem == 16'd1) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (last_fire) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      rem       <= '0;
      addr_hold <= '0;
      done_q    <= 1'b0;
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      if (cmd_fire) begin
        addr_q <= cmd_addr;
        rem    <= cmd_len;
      end else if (issue) begin
        addr_q    <= addr_q + 16'(ADDR_STEP);
        rem       <= rem - 16'd1;
        addr_hold <= addr_q;
      end
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && (rem == 16'd1);
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (fifo_rd) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: out_valid masks whatever the entries hold.
  always_ff @(posedge clock) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= {pipe_last[READ_LAT-1], mem_rdata};
    end
  end

  fifo_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(fifo_wr && !fifo_rd && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_mlaccel_vecfetch.sv
// Bench for mlaccel_vecfetch: behavioural 2-cycle memory, scoreboard of expected beats,
// a command table plus hand-written backpressure and mid-command reset sequences.
module tb_mlaccel_vecfetch;

  localparam int STEP = 4;

  logic        clock;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [15:0] mem_addr;
  logic [1:0]  mem_wen;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  mlaccel_vecfetch #(
    .READ_LAT  (2),
    .FIFO_DEPTH(4),
    .ADDR_STEP (STEP)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .mem_addr (mem_addr),
    .mem_wen  (mem_wen),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: w[i] = i, two register stages between address and data.
  logic [15:0] wmem [65536];
  logic [63:0] mem_s1;

  initial begin
    for (int i = 0; i < 65536; i++) wmem[i] = 16'(i);
  end

  function automatic logic [63:0] rd64(input logic [15:0] a);
    logic [15:0] a1, a2, a3;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    a3 = a + 16'd3;
    return {wmem[a3], wmem[a2], wmem[a1], wmem[a]};
  endfunction

  always @(posedge clock) begin
    mem_s1    <= rd64(mem_addr);
    mem_rdata <= mem_s1;
  end

  int          checks = 0;
  int          passed = 0;
  int          t0 = 0;
  int          beat_count = 0;
  int          beat_rel[$];
  logic [64:0] exp_q[$];
  logic [63:0] first_data;
  logic        busy_seen;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;
  logic [64:0] exp_beat;

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] want);
    checks++;
    if (act === want) passed++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
  endtask

  // Output monitor: pops the scoreboard on every accepted beat and checks stall stability.
  always @(negedge clock) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        checkOutput("hold_stable", {6'd0, out_valid, out_last, out_data},
                    {6'd0, 1'b1, prev_last, prev_data});
      if (out_valid && out_ready) begin
        beat_rel.push_back(cyc - t0);
        if (beat_count == 0) first_data = out_data;
        beat_count++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_beat: got %h, want no beat", out_data);
        end else begin
          exp_beat = exp_q.pop_front();
          checkOutput("beat", {7'd0, out_last, out_data}, {7'd0, exp_beat});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] len);
    logic [15:0] a;
    @(posedge clock);
    #1;
    cmd_valid  = 1'b1;
    cmd_addr   = addr;
    cmd_len    = len;
    t0         = cyc;
    beat_count = 0;
    beat_rel.delete();
    busy_seen  = 1'b0;
    for (int b = 0; b < int'(len); b++) begin
      a = addr + 16'(STEP * b);
      exp_q.push_back({(b == int'(len) - 1), rd64(a)});
    end
    @(negedge clock);
    checkOutput("cmd_ready", 72'(cmd_ready), 72'(1));
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int rel);
    logic got;
    got = 1'b0;
    rel = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      busy_seen = busy_seen | busy;
      if (done) begin
        got = 1'b1;
        rel = cyc - t0;
      end
    end
    if (!got) begin
      checks++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles, want a done pulse", budget);
    end else begin
      @(negedge clock);
      checkOutput("done_pulse_width", 72'(done), 72'(0));
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] len;
    logic [63:0] first;
    int          beats;
    int          done_rel;
    logic [15:0] hold;
  } vec_t;

  vec_t vecs[6];
  int   rel;

  initial begin
    vecs[0] = '{16'h0005, 16'd2, 64'h0008_0007_0006_0005, 2, 6, 16'h0009};
    vecs[1] = '{16'h0000, 16'd0, 64'h0,                   0, 1, 16'h0009};
    vecs[2] = '{16'hFFFC, 16'd2, 64'hFFFF_FFFE_FFFD_FFFC, 2, 6, 16'h0000};
    vecs[3] = '{16'h1234, 16'd5, 64'h1237_1236_1235_1234, 5, 9, 16'h1244};
    vecs[4] = '{16'h00FE, 16'd1, 64'h0101_0100_00FF_00FE, 1, 5, 16'h00FE};
    vecs[5] = '{16'h0040, 16'd4, 64'h0043_0042_0041_0040, 4, 8, 16'h004C};

    resetn    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    #3 resetn = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_cmd_ready", 72'(cmd_ready), 72'(1));
    checkOutput("rst_mem_addr",  72'(mem_addr),  72'(0));
    checkOutput("rst_mem_wen",   72'(mem_wen),   72'(0));
    checkOutput("rst_out_valid", 72'(out_valid), 72'(0));
    checkOutput("rst_out_last",  72'(out_last),  72'(0));
    checkOutput("rst_busy",      72'(busy),      72'(0));
    checkOutput("rst_done",      72'(done),      72'(0));
    @(posedge clock);
    #1 resetn = 1'b1;

    // Basic command: addresses per cycle, beat timing, done timing.
    out_ready = 1'b1;
    applyStimulus(16'h0010, 16'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("t1_mem_addr", 72'(mem_addr), 72'(16'h0010 + 16'(4 * k)));
    end
    waitDone(50, rel);
    checkOutput("t1_done_cycle", 72'(rel), 72'(7));
    checkOutput("t1_beat_count", 72'(beat_rel.size()), 72'(3));
    for (int i = 0; i < beat_rel.size(); i++)
      checkOutput("t1_beat_cycle", 72'(beat_rel[i]), 72'(4 + i));

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].addr, vecs[v].len);
      waitDone(100, rel);
      checkOutput("vec_done_cycle", 72'(rel), 72'(vecs[v].done_rel));
      checkOutput("vec_beats", 72'(beat_count), 72'(vecs[v].beats));
      if (vecs[v].beats > 0) checkOutput("vec_first_data", 72'(first_data), 72'(vecs[v].first));
      checkOutput("vec_busy_seen", 72'(busy_seen), 72'(vecs[v].beats != 0));
      checkOutput("vec_addr_hold", 72'(mem_addr), 72'(vecs[v].hold));
      checkOutput("vec_sb_empty", 72'(exp_q.size()), 72'(0));
    end

    // Backpressure: out_ready low for cycles 3..20, stray command while busy.
    out_ready = 1'b1;
    applyStimulus(16'h0100, 16'd16);
    fork
      begin
        for (int r = 1; r <= 22; r++) begin
          out_ready = !(r >= 3 && r <= 20);
          @(posedge clock);
          #1;
        end
      end
      begin
        repeat (10) @(negedge clock);
        checkOutput("t3_stall_addr", 72'(mem_addr), 72'(16'h010C));
        checkOutput("t3_valid_held", 72'(out_valid), 72'(1));
        checkOutput("t3_cmd_ready", 72'(cmd_ready), 72'(0));
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = 16'hAAAA;
        cmd_len   = 16'd9;
        repeat (2) @(negedge clock);
        cmd_valid = 1'b0;
      end
      begin
        waitDone(200, rel);
      end
    join
    checkOutput("t3_beats", 72'(beat_count), 72'(16));
    checkOutput("t3_sb_empty", 72'(exp_q.size()), 72'(0));

    // Reset with two reads in flight and two beats parked in the FIFO.
    out_ready = 1'b0;
    applyStimulus(16'h0200, 16'd8);
    repeat (5) @(negedge clock);
    checkOutput("t6_pre_valid", 72'(out_valid), 72'(1));
    checkOutput("t6_pre_data", 72'(out_data), 72'(64'h0203_0202_0201_0200));
    checkOutput("t6_pre_addr", 72'(mem_addr), 72'(16'h020C));
    #2 resetn = 1'b0;
    #1;
    checkOutput("t6_rst_cmd_ready", 72'(cmd_ready), 72'(1));
    checkOutput("t6_rst_mem_addr",  72'(mem_addr),  72'(0));
    checkOutput("t6_rst_out_valid", 72'(out_valid), 72'(0));
    checkOutput("t6_rst_out_last",  72'(out_last),  72'(0));
    checkOutput("t6_rst_busy",      72'(busy),      72'(0));
    checkOutput("t6_rst_done",      72'(done),      72'(0));
    exp_q.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("t6_post_valid", 72'(out_valid), 72'(0));
    end
    applyStimulus(16'h0300, 16'd2);
    waitDone(100, rel);
    checkOutput("t6_done_cycle", 72'(rel), 72'(6));
    checkOutput("t6_beats", 72'(beat_count), 72'(2));
    checkOutput("t6_first_data", 72'(first_data), 72'(64'h0303_0302_0301_0300));
    checkOutput("t6_sb_empty", 72'(exp_q.size()), 72'(0));

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
